// File: rtl/tft43_pkg.sv
// ============================================================================
// tft43_pkg : shared encodings, command codes and state type for the TFT43
//             fill sequencer.                               Rev 1.0
// ============================================================================
`default_nettype none

package tft43_pkg;

    localparam logic [1:0] TRIG_RESET    = 2'b00;
    localparam logic [1:0] TRIG_CMD      = 2'b01;
    localparam logic [1:0] TRIG_DATA     = 2'b10;
    localparam logic [1:0] TRIG_CMD_DATA = 2'b11;

    localparam logic [15:0] CMD_CASET = 16'h002A;
    localparam logic [15:0] CMD_PASET = 16'h002B;
    localparam logic [15:0] CMD_RAMWR = 16'h002C;

    localparam int INIT_LEN_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LCDRST = 3'd1,
        ST_INIT   = 3'd2,
        ST_CASET  = 3'd3,
        ST_PASET  = 3'd4,
        ST_RAMWR  = 3'd5,
        ST_FILL   = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/tft43_init_rom.sv
// ============================================================================
// tft43_init_rom : combinational panel init table, index -> {cmd, data}.
//                                                            Rev 1.0
// ============================================================================
`default_nettype none

module tft43_init_rom
    import tft43_pkg::*;
#(
    parameter int INIT_LEN = INIT_LEN_DEF
)(
    input  logic [7:0]  idx,
    output logic [15:0] cmd,
    output logic [15:0] data
);

    always_comb begin
        cmd  = 16'h0000;
        data = 16'h0000;
        if (int'(idx) < INIT_LEN) begin
            case (idx)
                8'd0:    begin cmd = 16'h0011; data = 16'h0000; end
                8'd1:    begin cmd = 16'h0036; data = 16'h0048; end
                8'd2:    begin cmd = 16'h003A; data = 16'h0055; end
                8'd3:    begin cmd = 16'h00B1; data = 16'h0010; end
                8'd4:    begin cmd = 16'h00B6; data = 16'h000A; end
                8'd5:    begin cmd = 16'h00C0; data = 16'h0021; end
                8'd6:    begin cmd = 16'h0013; data = 16'h0000; end
                8'd7:    begin cmd = 16'h0029; data = 16'h0000; end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/tft43_fill_ctrl.sv
// ============================================================================
// tft43_fill_ctrl : LCD reset, init playback, window set-up and solid fill
//                   sequencer. Optional watchdog: TFT43_DONE_WDOG_EN. Rev 1.0
// ============================================================================
`default_nettype none

module tft43_fill_ctrl
    import tft43_pkg::*;
#(
    parameter int H_RES    = 480,
    parameter int V_RES    = 272,
    parameter int INIT_LEN = INIT_LEN_DEF
`ifdef TFT43_DONE_WDOG_EN
    ,
    parameter int TIMEOUT_CYC = 4096
`endif
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] fill_color,
    output logic        busy,
    output logic        frame_done,
    output logic        err,
    output logic        tim_en,
    output logic [1:0]  tim_trigger,
    output logic [15:0] tim_data1,
    output logic [15:0] tim_data2,
    input  logic        tim_done
);

    localparam logic [16:0] PIX_LAST  = 17'(H_RES * V_RES - 1);
    localparam logic [7:0]  INIT_LAST = 8'(INIT_LEN - 1);

    state_t      state, state_nxt;
    logic [7:0]  step, step_nxt;
    logic [16:0] pix, pix_nxt;
    logic [15:0] color, color_nxt;
    logic        gap, gap_nxt;
    logic        inited, inited_nxt;
    logic        frame_done_nxt;
    logic        op_done;
    logic        abort;
    logic [15:0] rom_cmd, rom_data;
    logic [15:0] win_last;

    assign op_done  = tim_en & tim_done;
    assign busy     = (state != ST_IDLE);
    assign tim_en   = busy & ~gap;
    assign win_last = (state == ST_CASET) ? 16'(H_RES - 1) : 16'(V_RES - 1);

    tft43_init_rom #(
        .INIT_LEN (INIT_LEN)
    ) u_rom (
        .idx  (step),
        .cmd  (rom_cmd),
        .data (rom_data)
    );

`ifdef TFT43_DONE_WDOG_EN
    localparam logic [12:0] WDOG_LAST = 13'(TIMEOUT_CYC - 1);
    logic [12:0] wdog;

    assign abort = tim_en & ~tim_done & (wdog == WDOG_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog <= 13'd0;
            err  <= 1'b0;
        end else begin
            wdog <= (tim_en && !tim_done) ? wdog + 13'd1 : 13'd0;
            if (abort)
                err <= 1'b1;
        end
    end
`else
    assign abort = 1'b0;
    assign err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            step       <= 8'd0;
            pix        <= 17'd0;
            color      <= 16'h0000;
            gap        <= 1'b0;
            inited     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            step       <= step_nxt;
            pix        <= pix_nxt;
            color      <= color_nxt;
            gap        <= gap_nxt;
            inited     <= inited_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    // Every accepted done inserts one idle gap cycle before the next op.
    always_comb begin
        state_nxt      = state;
        step_nxt       = step;
        pix_nxt        = pix;
        color_nxt      = color;
        gap_nxt        = 1'b0;
        inited_nxt     = inited;
        frame_done_nxt = 1'b0;
        if (state == ST_IDLE) begin
            if (start) begin
                color_nxt = fill_color;
                step_nxt  = 8'd0;
                pix_nxt   = 17'd0;
                state_nxt = inited ? ST_CASET : ST_LCDRST;
            end
        end else if (op_done) begin
            gap_nxt  = 1'b1;
            step_nxt = step + 8'd1;
            case (state)
                ST_LCDRST: begin
                    inited_nxt = 1'b1;
                    step_nxt   = 8'd0;
                    state_nxt  = ST_INIT;
                end
                ST_INIT: if (step == INIT_LAST) begin
                    step_nxt  = 8'd0;
                    state_nxt = ST_CASET;
                end
                ST_CASET: if (step == 8'd3) begin
                    step_nxt  = 8'd0;
                    state_nxt = ST_PASET;
                end
                ST_PASET: if (step == 8'd3) begin
                    step_nxt  = 8'd0;
                    state_nxt = ST_RAMWR;
                end
                ST_RAMWR: begin
                    step_nxt  = 8'd0;
                    state_nxt = ST_FILL;
                end
                ST_FILL: begin
                    step_nxt = 8'd0;
                    pix_nxt  = pix + 17'd1;
                    if (pix == PIX_LAST) begin
                        pix_nxt        = 17'd0;
                        gap_nxt        = 1'b0;
                        frame_done_nxt = 1'b1;
                        state_nxt      = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end else if (abort) begin
            state_nxt  = ST_IDLE;
            step_nxt   = 8'd0;
            pix_nxt    = 17'd0;
            inited_nxt = 1'b0;
        end
    end

    always_comb begin
        tim_trigger = TRIG_RESET;
        tim_data1   = 16'h0000;
        tim_data2   = 16'h0000;
        case (state)
            ST_INIT: begin
                tim_trigger = TRIG_CMD_DATA;
                tim_data1   = rom_cmd;
                tim_data2   = rom_data;
            end
            ST_CASET, ST_PASET: begin
                case (step[1:0])
                    2'd0: begin
                        tim_trigger = TRIG_CMD_DATA;
                        tim_data1   = (state == ST_CASET) ? CMD_CASET : CMD_PASET;
                    end
                    2'd1: tim_trigger = TRIG_DATA;
                    2'd2: begin
                        tim_trigger = TRIG_DATA;
                        tim_data1   = {8'h00, win_last[15:8]};
                    end
                    default: begin
                        tim_trigger = TRIG_DATA;
                        tim_data1   = {8'h00, win_last[7:0]};
                    end
                endcase
            end
            ST_RAMWR: begin
                tim_trigger = TRIG_CMD;
                tim_data1   = CMD_RAMWR;
            end
            ST_FILL: begin
                tim_trigger = TRIG_DATA;
                tim_data1   = color;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_tft43_fill_ctrl.sv
// ============================================================================
// tb_tft43_fill_ctrl : scoreboard bench for tft43_fill_ctrl with a randomly
//                      delayed done responder.                Rev 1.0
// ============================================================================
`default_nettype none

module tb_tft43_fill_ctrl;

    localparam int TB_H  = 260;
    localparam int TB_V  = 12;
    localparam int PIX   = TB_H * TB_V;
    localparam int LIMIT = 40000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] fill_color;
    logic        busy, frame_done, err, tim_en;
    logic [1:0]  tim_trigger;
    logic [15:0] tim_data1, tim_data2;
    logic        tim_done = 1'b0;

    logic [15:0] rom_cmd [0:7] = '{16'h0011, 16'h0036, 16'h003A, 16'h00B1,
                                   16'h00B6, 16'h00C0, 16'h0013, 16'h0029};
    logic [15:0] rom_dat [0:7] = '{16'h0000, 16'h0048, 16'h0055, 16'h0010,
                                   16'h000A, 16'h0021, 16'h0000, 16'h0000};

    logic [33:0] sb [$];
    logic [33:0] held;
    int          n_vec     = 0;
    int          n_err     = 0;
    int          fd_count  = 0;
    int          fd_base   = 0;
    int          wait_cnt  = 0;
    logic        in_req    = 1'b0;
    logic        done_sent = 1'b0;
    logic        post_gap  = 1'b0;
    logic        hold_done = 1'b0;
    logic        inited_m  = 1'b0;

    always #5 clk = ~clk;

    tft43_fill_ctrl #(
        .H_RES (TB_H),
        .V_RES (TB_V)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .fill_color  (fill_color),
        .busy        (busy),
        .frame_done  (frame_done),
        .err         (err),
        .tim_en      (tim_en),
        .tim_trigger (tim_trigger),
        .tim_data1   (tim_data1),
        .tim_data2   (tim_data2),
        .tim_done    (tim_done)
    );

    // Fields the op does not define are zeroed so they never affect the compare.
    function automatic logic [33:0] pack(input logic [1:0] t, input logic [15:0] d1,
                                         input logic [15:0] d2);
        return {t, (t == 2'b00) ? 16'h0000 : d1, (t == 2'b11) ? d2 : 16'h0000};
    endfunction

    task automatic check_val(input string tag, input logic [33:0] got, input logic [33:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_busy"},  34'(busy),        34'd0);
        check_val({tag, "_fdone"}, 34'(frame_done),  34'd0);
        check_val({tag, "_err"},   34'(err),         34'd0);
        check_val({tag, "_en"},    34'(tim_en),      34'd0);
        check_val({tag, "_trig"},  34'(tim_trigger), 34'd0);
        check_val({tag, "_d1"},    34'(tim_data1),   34'd0);
        check_val({tag, "_d2"},    34'(tim_data2),   34'd0);
    endtask

    task automatic push_frame(input logic [15:0] color);
        if (!inited_m) begin
            sb.push_back(pack(2'b00, 16'h0000, 16'h0000));
            for (int i = 0; i < 8; i++)
                sb.push_back(pack(2'b11, rom_cmd[i], rom_dat[i]));
            inited_m = 1'b1;
        end
        sb.push_back(pack(2'b11, 16'h002A, 16'h0000));
        sb.push_back(pack(2'b10, 16'h0000, 16'h0000));
        sb.push_back(pack(2'b10, 16'((TB_H - 1) >> 8), 16'h0000));
        sb.push_back(pack(2'b10, 16'((TB_H - 1) & 255), 16'h0000));
        sb.push_back(pack(2'b11, 16'h002B, 16'h0000));
        sb.push_back(pack(2'b10, 16'h0000, 16'h0000));
        sb.push_back(pack(2'b10, 16'((TB_V - 1) >> 8), 16'h0000));
        sb.push_back(pack(2'b10, 16'((TB_V - 1) & 255), 16'h0000));
        sb.push_back(pack(2'b01, 16'h002C, 16'h0000));
        for (int p = 0; p < PIX; p++)
            sb.push_back(pack(2'b10, color, 16'h0000));
    endtask

    task automatic start_frame(input logic [15:0] color);
        @(negedge clk);
        push_frame(color);
        fd_base    = fd_count;
        start      = 1'b1;
        fill_color = color;
        @(negedge clk);
        start = 1'b0;
        check_val("busy_on", 34'(busy), 34'd1);
    endtask

    task automatic wait_frame(input string tag);
        int n = 0;
        while (!frame_done && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_done"}, 34'(frame_done), 34'd1);
        repeat (4) @(negedge clk);
        check_val({tag, "_fd_pulses"}, 34'(fd_count - fd_base), 34'd1);
        check_val({tag, "_ops_left"},  34'(sb.size()),          34'd0);
        check_val({tag, "_busy_off"},  34'(busy),               34'd0);
    endtask

    task automatic wait_half();
        int n = 0;
        while (sb.size() > PIX / 2 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check_val("half_reached", 34'(sb.size() <= PIX / 2), 34'd1);
    endtask

    // Monitor and done responder; samples on the falling edge, drives done there too.
    always @(negedge clk) begin : mon
        logic [33:0] obs;
        logic        sent_prev;
        obs       = pack(tim_trigger, tim_data1, tim_data2);
        sent_prev = done_sent;
        done_sent = 1'b0;
        tim_done  = 1'b0;
        if (frame_done)
            fd_count++;
        if (!rst_n) begin
            sb.delete();
            in_req   = 1'b0;
            post_gap = 1'b0;
        end else begin
            if (sent_prev) begin
                in_req   = 1'b0;
                post_gap = 1'b1;
                check_val("gap", 34'(tim_en), 34'd0);
                if ($urandom_range(0, 3) == 0)
                    tim_done = 1'b1;
            end else if (post_gap) begin
                post_gap = 1'b0;
                if (busy)
                    check_val("gap_len", 34'(tim_en), 34'd1);
            end
            if (!tim_en) begin
                in_req = 1'b0;
            end else if (!in_req) begin
                if (sb.size() == 0)
                    check_val("extra_op", 34'(sb.size()), 34'd1);
                else
                    check_val("op", obs, sb.pop_front());
                in_req   = 1'b1;
                held     = obs;
                wait_cnt = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 20)) : 0;
            end else begin
                check_val("stable", obs, held);
            end
            if (tim_en && !hold_done) begin
                if (wait_cnt == 0) begin
                    tim_done  = 1'b1;
                    done_sent = 1'b1;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        fill_color = 16'h0000;
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;

        start_frame(16'hF800);
        wait_frame("f1");

        start_frame(16'h07E0);
        wait_half();
        start      = 1'b1;
        fill_color = 16'h001F;
        @(negedge clk);
        start = 1'b0;
        check_val("busy_fill", 34'(busy), 34'd1);
        wait_frame("f2");

        start_frame(16'h1234);
        wait_half();
        rst_n    = 1'b0;
        inited_m = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("mid_rst");
        rst_n = 1'b1;
        start_frame(16'hABCD);
        wait_frame("f3");

`ifdef TFT43_DONE_WDOG_EN
        begin
            int n = 0;
            hold_done = 1'b1;
            @(negedge clk);
            sb.push_back(pack(2'b00, 16'h0000, 16'h0000));
            start      = 1'b1;
            fill_color = 16'h5555;
            @(negedge clk);
            start = 1'b0;
            while (!err && n < 6000) begin
                @(negedge clk);
                n++;
            end
            check_val("wdog_err",    34'(err),                     34'd1);
            check_val("wdog_cycles", 34'(n >= 4094 && n <= 4098),  34'd1);
            check_val("wdog_busy",   34'(busy),                    34'd0);
            check_val("wdog_en",     34'(tim_en),                  34'd0);
            check_val("wdog_ops",    34'(sb.size()),               34'd0);
            hold_done = 1'b0;
            inited_m  = 1'b0;
            start_frame(16'h0F0F);
            wait_frame("f4");
            check_val("err_sticky", 34'(err), 34'd1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
